// File: rtl/wb_pkg.sv
// Shared widths and bus field layout for the writeback retire queue.
// The same layout is used by MEM (producer bus) and ID (ws_to_ds_bus consumer).
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int DEPTH_DEF  = 2;

  // MEM->WB bus: {pc, gr_we, dest, result}, MSB first
  function automatic int result_lsb();
    return 0;
  endfunction

  function automatic int dest_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int grwe_bit(input int data_w, input int reg_aw);
    return data_w + reg_aw;
  endfunction

  function automatic int pc_lsb(input int data_w, input int reg_aw);
    return data_w + reg_aw + 1;
  endfunction

  function automatic int bus_w(input int pc_w, input int data_w, input int reg_aw);
    return pc_w + 1 + reg_aw + data_w;
  endfunction

  // WB->ID bus: {rf_we, rf_waddr, rf_wdata}
  function automatic int tods_wdata_lsb();
    return 0;
  endfunction

  function automatic int tods_waddr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int tods_we_bit(input int data_w, input int reg_aw);
    return data_w + reg_aw;
  endfunction

  function automatic int tods_w(input int data_w, input int reg_aw);
    return 1 + reg_aw + data_w;
  endfunction

endpackage

// File: rtl/wb_retire_queue_if.sv
// MEM->WB valid/allowin handshake with the packed result bus.
interface wb_retire_queue_if
  import wb_pkg::*;
#(
  parameter int BUS_W = bus_w(PC_W_DEF, DATA_W_DEF, REG_AW_DEF)
);
  logic             ms_to_ws_valid;
  logic [BUS_W-1:0] ms_to_ws_bus;
  logic             ws_allowin;

  modport master (output ms_to_ws_valid, output ms_to_ws_bus, input  ws_allowin);
  modport slave  (input  ms_to_ws_valid, input  ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_fifo.sv
// Generic in-order FIFO with flush, occupancy and per-slot valid bits.
// A tag slice of every slot is exported so the owner can scan pending entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int W       = 70,
  parameter int TAG_LSB = 32,
  parameter int TAG_W   = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic [W-1:0]                din_i,
  output logic [W-1:0]                head_o,
  output logic [DEPTH-1:0][TAG_W-1:0] tag_o,
  output logic [DEPTH-1:0]            vld_o,
  output logic [$clog2(DEPTH):0]      cnt_o,
  output logic                        full_o,
  output logic                        empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload is not reset; every consumer qualifies it with count/valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o = mem_q[rd_q];

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [AW-1:0] IDX = AW'(i);
    logic [AW-1:0] off;
    assign off      = IDX - rd_q;
    assign vld_o[i] = ({1'b0, off} < cnt_q);
    assign tag_o[i] = mem_q[i][TAG_LSB +: TAG_W];
  end

endmodule

// File: rtl/wb_retire_queue.sv
// Writeback retire queue: buffers MEM results and retires one per cycle into
// the register file, with ID bypass/pending-mask outputs and debug trace.
module wb_retire_queue
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         resetn,
  wb_retire_queue_if.slave             ms,
  input  logic                         wb_stall,
  input  logic                         ws_flush,
  output logic [tods_w(DATA_W,REG_AW)-1:0] ws_to_ds_bus,
  output logic [(1<<REG_AW)-1:0]       ws_pending_mask,
  output logic [31:0]                  ws_retire_cnt,
  output logic [PC_W-1:0]              debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_we,
  output logic [REG_AW-1:0]            debug_wb_rf_wnum,
  output logic [DATA_W-1:0]            debug_wb_rf_wdata
);
  localparam int BUS_W    = bus_w(PC_W, DATA_W, REG_AW);
  localparam int AW       = $clog2(DEPTH);
  localparam int DEST_LSB = dest_lsb(DATA_W);
  localparam int GRWE     = grwe_bit(DATA_W, REG_AW);
  localparam int PC_LSB   = pc_lsb(DATA_W, REG_AW);
  localparam int RES_LSB  = result_lsb();
  localparam int TAG_W    = REG_AW + 1;
  localparam int TD_DATA  = tods_wdata_lsb();
  localparam int TD_ADDR  = tods_waddr_lsb(DATA_W);
  localparam int TD_WE    = tods_we_bit(DATA_W, REG_AW);

  logic [BUS_W-1:0]            head;
  logic [DEPTH-1:0][TAG_W-1:0] tag;
  logic [DEPTH-1:0]            vld;
  logic [AW:0]                 cnt;
  logic                        full, empty;
  logic                        push, retire, rf_we;
  logic [PC_W-1:0]             h_pc;
  logic                        h_we;
  logic [REG_AW-1:0]           h_dest;
  logic [DATA_W-1:0]           h_res;
  logic [31:0]                 retire_cnt_q, retire_cnt_d;

  // allowin looks only at registered occupancy: a full queue never passes through.
  assign ms.ws_allowin = !full;
  assign push          = ms.ms_to_ws_valid && !full && !ws_flush;
  assign retire        = !empty && !wb_stall && !ws_flush;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .W      (BUS_W),
    .TAG_LSB(DEST_LSB),
    .TAG_W  (TAG_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (resetn),
    .push_i (push),
    .pop_i  (retire),
    .flush_i(ws_flush),
    .din_i  (ms.ms_to_ws_bus),
    .head_o (head),
    .tag_o  (tag),
    .vld_o  (vld),
    .cnt_o  (cnt),
    .full_o (full),
    .empty_o(empty)
  );

  assign h_pc   = head[PC_LSB +: PC_W];
  assign h_we   = head[GRWE];
  assign h_dest = head[DEST_LSB +: REG_AW];
  assign h_res  = head[RES_LSB +: DATA_W];
  assign rf_we  = retire && h_we;

  always_comb begin
    ws_to_ds_bus                       = '0;
    ws_to_ds_bus[TD_WE]                = rf_we;
    ws_to_ds_bus[TD_ADDR +: REG_AW]    = empty ? '0 : h_dest;
    ws_to_ds_bus[TD_DATA +: DATA_W]    = empty ? '0 : h_res;
  end

  // Retiring head stays in the mask during its retire cycle; r0 never stalls ID.
  always_comb begin
    ws_pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && tag[i][REG_AW]) ws_pending_mask[tag[i][REG_AW-1:0]] = 1'b1;
    end
    ws_pending_mask[0] = 1'b0;
  end

  assign retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) retire_cnt_q <= '0;
    else         retire_cnt_q <= retire_cnt_d;
  end

  assign ws_retire_cnt     = retire_cnt_q;
  assign debug_wb_pc       = rf_we ? h_pc   : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_we ? h_dest : '0;
  assign debug_wb_rf_wdata = rf_we ? h_res  : '0;

  // Occupancy is observable through cnt only for completeness of the FIFO view.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue: latency, stall/backpressure, streaming,
// flush, non-writing entries, r0 handling and asynchronous reset.
module tb_wb_retire_queue;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 2;
  localparam int BUS_W  = PC_W + 1 + REG_AW + DATA_W;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_stall, ws_flush;
  logic [37:0] ws_to_ds_bus;
  logic [31:0] ws_pending_mask;
  logic [31:0] ws_retire_cnt;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_retire_queue_if #(.BUS_W(BUS_W)) ms ();

  wb_retire_queue #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .ms               (ms),
    .wb_stall         (wb_stall),
    .ws_flush         (ws_flush),
    .ws_to_ds_bus     (ws_to_ds_bus),
    .ws_pending_mask  (ws_pending_mask),
    .ws_retire_cnt    (ws_retire_cnt),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_we   (debug_wb_rf_we),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc, input logic we,
                                          input logic [4:0] d, input logic [31:0] r);
    return {pc, we, d, r};
  endfunction

  function automatic logic [63:0] bit_of(input int d);
    logic [63:0] one;
    one = 64'd1;
    return one << d;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drv(input logic v, input logic [BUS_W-1:0] b, input logic st, input logic fl);
    @(negedge clk);
    ms.ms_to_ws_valid = v;
    ms.ms_to_ws_bus   = b;
    wb_stall          = st;
    ws_flush          = fl;
    #1;
  endtask

  task automatic chk_ret(input string tag, input logic we, input logic [4:0] d,
                         input logic [31:0] data, input logic [31:0] pc);
    chk({tag, "_we"},   64'(debug_wb_rf_we),    64'({4{we}}));
    chk({tag, "_wnum"}, 64'(debug_wb_rf_wnum),  we ? 64'(d) : 64'd0);
    chk({tag, "_wdat"}, 64'(debug_wb_rf_wdata), we ? 64'(data) : 64'd0);
    chk({tag, "_pc"},   64'(debug_wb_pc),       we ? 64'(pc) : 64'd0);
    chk({tag, "_tods"}, 64'(ws_to_ds_bus[37]),  64'(we));
  endtask

  logic [31:0] s_pc  [100];
  logic [4:0]  s_dst [100];
  logic [31:0] s_res [100];

  initial begin
    resetn            = 1'b0;
    wb_stall          = 1'b0;
    ws_flush          = 1'b0;
    ms.ms_to_ws_valid = 1'b0;
    ms.ms_to_ws_bus   = '0;
    #2;
    chk("rst_allowin", 64'(ms.ws_allowin), 64'd1);
    chk("rst_tods",    64'(ws_to_ds_bus), 64'd0);
    chk("rst_mask",    64'(ws_pending_mask), 64'd0);
    chk("rst_cnt",     64'(ws_retire_cnt), 64'd0);
    chk_ret("rst", 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // single entry: head next cycle, retires immediately
    drv(1'b1, mk(32'h1c00_0000, 1'b1, 5'd5, 32'hDEAD_BEEF), 1'b0, 1'b0);
    chk("one_allowin", 64'(ms.ws_allowin), 64'd1);
    chk_ret("one_idle", 1'b0, 5'd0, 32'd0, 32'd0);
    drv(1'b0, '0, 1'b0, 1'b0);
    chk_ret("one_ret", 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h1c00_0000);
    chk("one_tods", 64'(ws_to_ds_bus), {26'd0, 1'b1, 5'd5, 32'hDEAD_BEEF});
    chk("one_mask", 64'(ws_pending_mask), bit_of(5));
    chk("one_cnt0", 64'(ws_retire_cnt), 64'd0);
    drv(1'b0, '0, 1'b0, 1'b0);
    chk("one_cnt1", 64'(ws_retire_cnt), 64'd1);
    chk("one_mask0", 64'(ws_pending_mask), 64'd0);
    chk_ret("one_after", 1'b0, 5'd0, 32'd0, 32'd0);

    // stall: fill to DEPTH, third entry held by MEM
    drv(1'b1, mk(32'h100, 1'b1, 5'd3, 32'hAAAA_0003), 1'b1, 1'b0);
    chk("st_allow0", 64'(ms.ws_allowin), 64'd1);
    drv(1'b1, mk(32'h104, 1'b1, 5'd7, 32'hAAAA_0007), 1'b1, 1'b0);
    chk("st_allow1", 64'(ms.ws_allowin), 64'd1);
    chk("st_mask1",  64'(ws_pending_mask), bit_of(3));
    chk_ret("st_hold1", 1'b0, 5'd0, 32'd0, 32'd0);
    drv(1'b1, mk(32'h108, 1'b1, 5'd12, 32'hAAAA_000C), 1'b1, 1'b0);
    chk("st_allow2", 64'(ms.ws_allowin), 64'd0);
    chk("st_mask2",  64'(ws_pending_mask), bit_of(3) | bit_of(7));
    drv(1'b1, mk(32'h108, 1'b1, 5'd12, 32'hAAAA_000C), 1'b1, 1'b0);
    chk("st_allow3", 64'(ms.ws_allowin), 64'd0);
    chk("st_cnt3",   64'(ws_retire_cnt), 64'd1);
    drv(1'b1, mk(32'h108, 1'b1, 5'd12, 32'hAAAA_000C), 1'b0, 1'b0);
    chk_ret("st_r0", 1'b1, 5'd3, 32'hAAAA_0003, 32'h100);
    chk("st_allow4", 64'(ms.ws_allowin), 64'd0);
    chk("st_mask4",  64'(ws_pending_mask), bit_of(3) | bit_of(7));
    drv(1'b1, mk(32'h108, 1'b1, 5'd12, 32'hAAAA_000C), 1'b0, 1'b0);
    chk_ret("st_r1", 1'b1, 5'd7, 32'hAAAA_0007, 32'h104);
    chk("st_allow5", 64'(ms.ws_allowin), 64'd1);
    chk("st_mask5",  64'(ws_pending_mask), bit_of(7));
    drv(1'b0, '0, 1'b0, 1'b0);
    chk_ret("st_r2", 1'b1, 5'd12, 32'hAAAA_000C, 32'h108);
    chk("st_mask6",  64'(ws_pending_mask), bit_of(12));
    drv(1'b0, '0, 1'b0, 1'b0);
    chk("st_mask7",  64'(ws_pending_mask), 64'd0);
    chk("st_cnt7",   64'(ws_retire_cnt), 64'd4);

    // back-to-back stream of 100 entries
    for (int i = 0; i < 100; i++) begin
      s_pc[i]  = 32'h1c00_1000 + 32'(i) * 4;
      s_dst[i] = 5'((i % 31) + 1);
      s_res[i] = 32'h1234_0000 + 32'(i) * 7;
    end
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) drv(1'b1, mk(s_pc[i], 1'b1, s_dst[i], s_res[i]), 1'b0, 1'b0);
      else         drv(1'b0, '0, 1'b0, 1'b0);
      chk("strm_allow", 64'(ms.ws_allowin), 64'd1);
      if (i > 0) begin
        chk_ret("strm", 1'b1, s_dst[i-1], s_res[i-1], s_pc[i-1]);
        chk("strm_mask", 64'(ws_pending_mask), bit_of(int'(s_dst[i-1])));
      end
    end
    drv(1'b0, '0, 1'b0, 1'b0);
    chk("strm_cnt", 64'(ws_retire_cnt), 64'd104);

    // flush with queue full and a new entry presented
    drv(1'b1, mk(32'h200, 1'b1, 5'd4, 32'hBBBB_0004), 1'b1, 1'b0);
    drv(1'b1, mk(32'h204, 1'b1, 5'd6, 32'hBBBB_0006), 1'b1, 1'b0);
    drv(1'b1, mk(32'h208, 1'b1, 5'd8, 32'hBBBB_0008), 1'b0, 1'b1);
    chk("fl_allow", 64'(ms.ws_allowin), 64'd0);
    chk_ret("fl_cyc", 1'b0, 5'd0, 32'd0, 32'd0);
    chk("fl_mask_pre", 64'(ws_pending_mask), bit_of(4) | bit_of(6));
    drv(1'b0, '0, 1'b0, 1'b0);
    chk("fl_mask", 64'(ws_pending_mask), 64'd0);
    chk("fl_allow1", 64'(ms.ws_allowin), 64'd1);
    chk("fl_tods", 64'(ws_to_ds_bus), 64'd0);
    chk("fl_cnt", 64'(ws_retire_cnt), 64'd104);

    // gr_we=0 still retires and counts, but never writes or shows pending
    drv(1'b1, mk(32'h300, 1'b0, 5'd9, 32'hCCCC_0009), 1'b0, 1'b0);
    drv(1'b1, mk(32'h304, 1'b1, 5'd0, 32'hCCCC_0000), 1'b0, 1'b0);
    chk_ret("nowe", 1'b0, 5'd0, 32'd0, 32'd0);
    chk("nowe_mask", 64'(ws_pending_mask), 64'd0);
    drv(1'b0, '0, 1'b0, 1'b0);
    chk("nowe_cnt", 64'(ws_retire_cnt), 64'd105);
    chk_ret("r0", 1'b1, 5'd0, 32'hCCCC_0000, 32'h304);
    chk("r0_mask", 64'(ws_pending_mask), 64'd0);
    drv(1'b0, '0, 1'b0, 1'b0);
    chk("r0_cnt", 64'(ws_retire_cnt), 64'd106);

    // asynchronous reset while full and stalled
    drv(1'b1, mk(32'h400, 1'b1, 5'd10, 32'hDDDD_000A), 1'b1, 1'b0);
    drv(1'b1, mk(32'h404, 1'b1, 5'd11, 32'hDDDD_000B), 1'b1, 1'b0);
    drv(1'b0, '0, 1'b1, 1'b0);
    chk("ar_full", 64'(ms.ws_allowin), 64'd0);
    chk("ar_mask_pre", 64'(ws_pending_mask), bit_of(10) | bit_of(11));
    resetn = 1'b0;
    #1;
    chk("ar_allow", 64'(ms.ws_allowin), 64'd1);
    chk("ar_mask", 64'(ws_pending_mask), 64'd0);
    chk("ar_cnt", 64'(ws_retire_cnt), 64'd0);
    chk("ar_tods", 64'(ws_to_ds_bus), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    drv(1'b0, '0, 1'b0, 1'b0);
    chk("ar_allow2", 64'(ms.ws_allowin), 64'd1);
    chk_ret("ar_idle", 1'b0, 5'd0, 32'd0, 32'd0);
    drv(1'b0, '0, 1'b0, 1'b0);
    chk("ar_cnt2", 64'(ws_retire_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
